// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: MEM-stage load/store responder on a single-beat 64-bit valid/ready bus.
// Handles lane alignment, strobes, load extension, misalignment, flush-abandon and response timeout.
module dmem_responder #(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dcache_enable,
    input  logic              mem_is_load,
    input  logic              mem_is_store,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_wdata,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              mem_advance,
    output logic              dcache_valid,
    output logic              write_done,
    output logic [63:0]       rdata,
    output logic              misaligned,
    output logic              bus_error,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_write,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [63:0]       bus_req_wdata,
    output logic [7:0]        bus_req_strb,
    input  logic              bus_resp_valid,
    input  logic [63:0]       bus_resp_data
);
    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_is_load, w_is_load_nxt;
    logic [2:0]        r_off, w_off_nxt;
    logic [1:0]        r_size, w_size_nxt;
    logic              r_uns, w_uns_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_abandon, w_abandon_nxt;
    logic              r_dcache_valid, w_dcache_valid_nxt;
    logic              r_write_done, w_write_done_nxt;
    logic [63:0]       r_rdata, w_rdata_nxt;
    logic              r_misaligned, w_misaligned_nxt;
    logic              r_bus_error, w_bus_error_nxt;
    logic              r_req_valid, w_req_valid_nxt;
    logic              r_req_write, w_req_write_nxt;
    logic [ADDR_W-1:0] r_req_addr, w_req_addr_nxt;
    logic [63:0]       r_req_wdata, w_req_wdata_nxt;
    logic [7:0]        r_req_strb, w_req_strb_nxt;

    logic              w_req;
    logic              w_misaligned;
    logic [7:0]        w_strb;
    logic [63:0]       w_wdata_sh;
    logic [63:0]       w_resp_sh;
    logic              w_sext;
    logic [63:0]       w_load_data;
    logic              w_flush;

    assign w_req      = dcache_enable && (mem_is_load ^ mem_is_store);
    assign w_wdata_sh = mem_wdata << {mem_addr[2:0], 3'b000};
    assign w_resp_sh  = bus_resp_data >> {r_off, 3'b000};
    assign w_sext     = ~r_uns;
    assign w_flush    = r_abandon || !dcache_enable;

    // Alignment check and base strobe pattern from the access size
    always_comb begin
        w_misaligned = 1'b0;
        w_strb       = 8'h00;
        case (mem_size)
            2'd0: begin
                w_misaligned = 1'b0;
                w_strb       = 8'h01;
            end
            2'd1: begin
                w_misaligned = mem_addr[0];
                w_strb       = 8'h03;
            end
            2'd2: begin
                w_misaligned = |mem_addr[1:0];
                w_strb       = 8'h0F;
            end
            default: begin
                w_misaligned = |mem_addr[2:0];
                w_strb       = 8'hFF;
            end
        endcase
        w_strb = w_strb << mem_addr[2:0];
    end

    // Load result: lane-shifted response truncated to size, then extended
    always_comb begin
        w_load_data = w_resp_sh;
        case (r_size)
            2'd0:    w_load_data = {{56{w_sext & w_resp_sh[7]}},  w_resp_sh[7:0]};
            2'd1:    w_load_data = {{48{w_sext & w_resp_sh[15]}}, w_resp_sh[15:0]};
            2'd2:    w_load_data = {{32{w_sext & w_resp_sh[31]}}, w_resp_sh[31:0]};
            default: w_load_data = w_resp_sh;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt        = r_state;
        w_is_load_nxt      = r_is_load;
        w_off_nxt          = r_off;
        w_size_nxt         = r_size;
        w_uns_nxt          = r_uns;
        w_cnt_nxt          = r_cnt;
        w_abandon_nxt      = r_abandon;
        w_dcache_valid_nxt = r_dcache_valid;
        w_write_done_nxt   = r_write_done;
        w_rdata_nxt        = r_rdata;
        w_misaligned_nxt   = r_misaligned;
        w_bus_error_nxt    = r_bus_error;
        w_req_valid_nxt    = r_req_valid;
        w_req_write_nxt    = r_req_write;
        w_req_addr_nxt     = r_req_addr;
        w_req_wdata_nxt    = r_req_wdata;
        w_req_strb_nxt     = r_req_strb;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_is_load_nxt = mem_is_load;
                    w_off_nxt     = mem_addr[2:0];
                    w_size_nxt    = mem_size;
                    w_uns_nxt     = mem_unsigned;
                    if (w_misaligned) begin
                        w_state_nxt        = S_DONE;
                        w_misaligned_nxt   = 1'b1;
                        w_dcache_valid_nxt = mem_is_load;
                        w_write_done_nxt   = mem_is_store;
                        w_rdata_nxt        = 64'd0;
                    end else begin
                        w_state_nxt     = S_REQ;
                        w_req_valid_nxt = 1'b1;
                        w_req_write_nxt = mem_is_store;
                        w_req_addr_nxt  = {mem_addr[ADDR_W-1:3], 3'b000};
                        w_req_wdata_nxt = w_wdata_sh;
                        w_req_strb_nxt  = w_strb;
                    end
                end
            end
            S_REQ: begin
                if (!dcache_enable) w_abandon_nxt = 1'b1;
                if (bus_req_ready) begin
                    w_state_nxt     = S_WAIT;
                    w_cnt_nxt       = '0;
                    w_req_valid_nxt = 1'b0;
                    w_req_write_nxt = 1'b0;
                    w_req_addr_nxt  = '0;
                    w_req_wdata_nxt = 64'd0;
                    w_req_strb_nxt  = 8'h00;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!dcache_enable) w_abandon_nxt = 1'b1;
                // A response in the last allowed cycle still wins over the timeout
                if (bus_resp_valid || (r_cnt == CNT_LAST)) begin
                    w_cnt_nxt = '0;
                    if (w_flush) begin
                        w_state_nxt   = S_IDLE;
                        w_abandon_nxt = 1'b0;
                    end else begin
                        w_state_nxt        = S_DONE;
                        w_dcache_valid_nxt = r_is_load;
                        w_write_done_nxt   = ~r_is_load;
                        w_bus_error_nxt    = ~bus_resp_valid;
                        w_rdata_nxt        = (bus_resp_valid && r_is_load) ? w_load_data : 64'd0;
                    end
                end
            end
            S_DONE: begin
                if (mem_advance || !dcache_enable) begin
                    w_state_nxt        = S_IDLE;
                    w_dcache_valid_nxt = 1'b0;
                    w_write_done_nxt   = 1'b0;
                    w_rdata_nxt        = 64'd0;
                    w_misaligned_nxt   = 1'b0;
                    w_bus_error_nxt    = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_is_load      <= 1'b0;
            r_off          <= 3'd0;
            r_size         <= 2'd0;
            r_uns          <= 1'b0;
            r_cnt          <= '0;
            r_abandon      <= 1'b0;
            r_dcache_valid <= 1'b0;
            r_write_done   <= 1'b0;
            r_rdata        <= 64'd0;
            r_misaligned   <= 1'b0;
            r_bus_error    <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_write    <= 1'b0;
            r_req_addr     <= '0;
            r_req_wdata    <= 64'd0;
            r_req_strb     <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_is_load      <= w_is_load_nxt;
            r_off          <= w_off_nxt;
            r_size         <= w_size_nxt;
            r_uns          <= w_uns_nxt;
            r_cnt          <= w_cnt_nxt;
            r_abandon      <= w_abandon_nxt;
            r_dcache_valid <= w_dcache_valid_nxt;
            r_write_done   <= w_write_done_nxt;
            r_rdata        <= w_rdata_nxt;
            r_misaligned   <= w_misaligned_nxt;
            r_bus_error    <= w_bus_error_nxt;
            r_req_valid    <= w_req_valid_nxt;
            r_req_write    <= w_req_write_nxt;
            r_req_addr     <= w_req_addr_nxt;
            r_req_wdata    <= w_req_wdata_nxt;
            r_req_strb     <= w_req_strb_nxt;
        end
    end

    assign dcache_valid  = r_dcache_valid;
    assign write_done    = r_write_done;
    assign rdata         = r_rdata;
    assign misaligned    = r_misaligned;
    assign bus_error     = r_bus_error;
    assign bus_req_valid = r_req_valid;
    assign bus_req_write = r_req_write;
    assign bus_req_addr  = r_req_addr;
    assign bus_req_wdata = r_req_wdata;
    assign bus_req_strb  = r_req_strb;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// tb_dmem_responder: table vectors plus randomized transactions against a byte-level
// reference model, and hand-written flush / reset sequences.
module tb_dmem_responder;
    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_enable, mem_is_load, mem_is_store, mem_unsigned, mem_advance;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        dcache_valid, write_done, misaligned, bus_error;
    logic [63:0] rdata;
    logic        bus_req_valid, bus_req_ready, bus_req_write;
    logic [63:0] bus_req_addr, bus_req_wdata;
    logic [7:0]  bus_req_strb;
    logic        bus_resp_valid;
    logic [63:0] bus_resp_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(64), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .dcache_enable(dcache_enable), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_advance(mem_advance),
        .dcache_valid(dcache_valid), .write_done(write_done), .rdata(rdata),
        .misaligned(misaligned), .bus_error(bus_error),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data)
    );

    typedef struct {
        string       name;
        bit          ld;
        bit          st;
        logic [63:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] wdata;
        logic [63:0] resp;
        int          rdy;
        int          rsp;
        int          hold;
        bit          late;
        bit          exp_mis;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {dcache_valid, write_done, misaligned, bus_error, bus_req_valid}
    function automatic logic [63:0] flags();
        return {59'd0, dcache_valid, write_done, misaligned, bus_error, bus_req_valid};
    endfunction

    function automatic logic [7:0] m_strb(input int size, input int off);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < (1 << size); i++)
            if (off + i < 8) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] resp, input int size, input int off, input bit uns);
        logic [63:0] v;
        logic [63:0] mask;
        int          nbits;
        nbits = 8 << size;
        v = resp >> (8 * off);
        if (nbits == 64) return v;
        mask = (64'd1 << nbits) - 64'd1;
        v = v & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_req(input bit ld, input bit st, input logic [63:0] addr, input logic [1:0] size,
                           input bit uns, input logic [63:0] wdata);
        dcache_enable = 1'b1;
        mem_is_load   = ld;
        mem_is_store  = st;
        mem_addr      = addr;
        mem_size      = size;
        mem_unsigned  = uns;
        mem_wdata     = wdata;
    endtask

    task automatic clr_req();
        dcache_enable = 1'b0;
        mem_is_load   = 1'b0;
        mem_is_store  = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [63:0] wmask;
        logic [63:0] done_flags;
        logic [63:0] exp_rd;
        bit          timed_out;
        for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{v.exp_strb[i]}};
        mem_advance = 1'b0;
        set_req(v.ld, v.st, v.addr, v.size, v.uns, v.wdata);
        tick();
        if (v.ld == v.st) begin
            chk($sformatf("%s/no_req_c1", v.name), flags(), 64'd0);
            tick();
            chk($sformatf("%s/no_req_c2", v.name), flags(), 64'd0);
            clr_req();
            return;
        end
        timed_out = 1'b0;
        if (v.exp_mis) begin
            done_flags = {59'd0, v.ld, v.st, 1'b1, 1'b0, 1'b0};
            chk($sformatf("%s/mis_flags", v.name), flags(), done_flags);
            chk($sformatf("%s/mis_rdata", v.name), rdata, 64'd0);
        end else begin
            chk($sformatf("%s/req_flags", v.name), flags(), 64'd1);
            for (int i = 0; i <= v.rdy; i++) begin
                bus_req_ready = (i == v.rdy);
                chk($sformatf("%s/req_valid%0d", v.name, i), flags(), 64'd1);
                chk($sformatf("%s/req_write%0d", v.name, i), 64'(bus_req_write), 64'(v.st));
                chk($sformatf("%s/req_addr%0d", v.name, i), bus_req_addr, v.addr & ~64'h7);
                chk($sformatf("%s/req_strb%0d", v.name, i), 64'(bus_req_strb), 64'(v.exp_strb));
                if (v.st) chk($sformatf("%s/req_wdata%0d", v.name, i), bus_req_wdata & wmask, v.exp_wdata & wmask);
                tick();
            end
            bus_req_ready = 1'b0;
            timed_out = 1'b1;
            for (int d = 0; d < int'(MAXW); d++) begin
                chk($sformatf("%s/wait%0d", v.name, d), flags(), 64'd0);
                if (d == v.rsp) begin
                    bus_resp_valid = 1'b1;
                    bus_resp_data  = v.resp;
                    tick();
                    bus_resp_valid = 1'b0;
                    timed_out = 1'b0;
                    break;
                end
                tick();
            end
            done_flags = {59'd0, v.ld, v.st, 1'b0, timed_out, 1'b0};
        end
        exp_rd = timed_out ? 64'd0 : v.exp_rdata;
        chk($sformatf("%s/done_flags", v.name), flags(), done_flags);
        chk($sformatf("%s/done_rdata", v.name), rdata, exp_rd);
        for (int h = 0; h < v.hold; h++) begin
            if (v.late) begin
                bus_resp_valid = 1'b1;
                bus_resp_data  = '1;
            end
            tick();
            bus_resp_valid = 1'b0;
            chk($sformatf("%s/hold_flags%0d", v.name, h), flags(), done_flags);
            chk($sformatf("%s/hold_rdata%0d", v.name, h), rdata, exp_rd);
        end
        mem_advance = 1'b1;
        tick();
        mem_advance = 1'b0;
        clr_req();
        chk($sformatf("%s/adv_flags", v.name), flags(), 64'd0);
        chk($sformatf("%s/adv_rdata", v.name), rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   off;
        int   k;

        reset = 1'b1;
        clr_req();
        mem_addr = '0; mem_wdata = '0; mem_size = '0; mem_unsigned = 1'b0; mem_advance = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
        tick();
        tick();
        chk("reset_flags", flags(), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_payload", bus_req_addr | bus_req_wdata | 64'(bus_req_strb), 64'd0);
        reset = 1'b0;
        tick();

        // name, ld, st, addr, size, uns, wdata, resp, rdy, rsp, hold, late, mis, strb, wdata_exp, rdata_exp
        v = '{"lb_signed", 1'b1, 1'b0, 64'h1003, 2'd0, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 1, 1'b0, 1'b0, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
        vecs.push_back(v);
        v = '{"lwu", 1'b1, 1'b0, 64'h1004, 2'd2, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 1'b0, 1'b0, 8'hF0, 64'h0, 64'h0000_0000_DEAD_BEEF};
        vecs.push_back(v);
        v = '{"sh", 1'b0, 1'b1, 64'h2006, 2'd1, 1'b0, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 3, 1'b0, 1'b0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0};
        vecs.push_back(v);
        v = '{"lw_misaligned", 1'b1, 1'b0, 64'h1002, 2'd2, 1'b0, 64'h0, 64'h0, 0, 0, 1, 1'b0, 1'b1, 8'h00, 64'h0, 64'h0};
        vecs.push_back(v);
        v = '{"ld_uns_ignored", 1'b1, 1'b0, 64'h3000, 2'd3, 1'b1, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 0, 0, 1'b0, 1'b0, 8'hFF, 64'h0, 64'h8123_4567_89AB_CDEF};
        vecs.push_back(v);
        v = '{"lh_signed", 1'b1, 1'b0, 64'h100A, 2'd1, 1'b0, 64'h0, 64'h0000_0000_F00D_0000, 1, 2, 0, 1'b0, 1'b0, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_F00D};
        vecs.push_back(v);
        v = '{"lw_signed", 1'b1, 1'b0, 64'h1004, 2'd2, 1'b0, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 0, 1'b0, 1'b0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0001};
        vecs.push_back(v);
        v = '{"lhu", 1'b1, 1'b0, 64'h2002, 2'd1, 1'b1, 64'h0, 64'h0000_0000_8001_0000, 0, 0, 0, 1'b0, 1'b0, 8'h0C, 64'h0, 64'h0000_0000_0000_8001};
        vecs.push_back(v);
        v = '{"sd", 1'b0, 1'b1, 64'h4008, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0, 1'b0, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs.push_back(v);
        v = '{"sb", 1'b0, 1'b1, 64'h4005, 2'd0, 1'b0, 64'hA5, 64'h0, 2, 1, 0, 1'b0, 1'b0, 8'h20, 64'h0000_A500_0000_0000, 64'h0};
        vecs.push_back(v);
        v = '{"sd_misaligned", 1'b0, 1'b1, 64'h4004, 2'd3, 1'b0, 64'h0, 64'h0, 0, 0, 0, 1'b0, 1'b1, 8'h00, 64'h0, 64'h0};
        vecs.push_back(v);
        v = '{"backpressure_lbu", 1'b1, 1'b0, 64'h10FF, 2'd0, 1'b1, 64'h0, 64'hFF00_0000_0000_0000, 5, 3, 0, 1'b0, 1'b0, 8'h80, 64'h0, 64'h0000_0000_0000_00FF};
        vecs.push_back(v);
        v = '{"timeout_lw", 1'b1, 1'b0, 64'h1008, 2'd2, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 99, 2, 1'b1, 1'b0, 8'h0F, 64'h0, 64'h0};
        vecs.push_back(v);
        v = '{"both_set", 1'b1, 1'b1, 64'h1000, 2'd3, 1'b0, 64'h0, 64'h0, 0, 0, 0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0};
        vecs.push_back(v);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Randomized transactions against the byte-level model
        for (int n = 0; n < 48; n++) begin
            k      = int'($urandom_range(0, 9));
            v.name = $sformatf("rnd%0d", n);
            v.ld   = (k < 5) || (k == 9);
            v.st   = (k >= 5);
            v.size = 2'($urandom_range(0, 3));
            off    = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) off = off - (off % (1 << v.size));
            v.addr  = ({$urandom(), $urandom()} & ~64'h7) | 64'(off);
            v.uns   = 1'($urandom_range(0, 1));
            v.wdata = {$urandom(), $urandom()};
            v.resp  = {$urandom(), $urandom()};
            v.rdy   = int'($urandom_range(0, 3));
            v.rsp   = int'($urandom_range(0, 5));
            v.hold  = int'($urandom_range(0, 2));
            v.late  = 1'($urandom_range(0, 1));
            v.exp_mis   = (off % (1 << v.size)) != 0;
            v.exp_strb  = v.exp_mis ? 8'h00 : m_strb(int'(v.size), off);
            v.exp_wdata = v.wdata << (8 * off);
            v.exp_rdata = (v.ld && !v.st && !v.exp_mis && v.rsp < int'(MAXW))
                          ? m_load(v.resp, int'(v.size), off, v.uns) : 64'd0;
            run_txn(v);
        end

        // Flush during WAIT, with a new request raised before the old one drains
        set_req(1'b1, 1'b0, 64'h5000, 2'd3, 1'b0, 64'h0);
        tick();
        chk("abw_req", flags(), 64'd1);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        dcache_enable = 1'b0;
        tick();
        set_req(1'b1, 1'b0, 64'h6008, 2'd3, 1'b0, 64'h0);
        tick();
        chk("abw_not_serviced", flags(), 64'd0);
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'h1111_2222_3333_4444;
        tick();
        bus_resp_valid = 1'b0;
        chk("abw_no_done", flags(), 64'd0);
        chk("abw_no_rdata", rdata, 64'd0);
        tick();
        chk("abw_next_req", flags(), 64'd1);
        chk("abw_next_addr", bus_req_addr, 64'h6008);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'hCAFE_F00D_1234_5678;
        tick();
        bus_resp_valid = 1'b0;
        chk("abw_next_done", flags(), 64'h10);
        chk("abw_next_rdata", rdata, 64'hCAFE_F00D_1234_5678);
        mem_advance = 1'b1;
        tick();
        mem_advance = 1'b0;
        clr_req();

        // Flush during REQ: valid stays up until the handshake, then no completion
        set_req(1'b0, 1'b1, 64'h7000, 2'd3, 1'b0, 64'h55);
        tick();
        dcache_enable = 1'b0;
        tick();
        chk("abr_valid_held1", flags(), 64'd1);
        tick();
        chk("abr_valid_held2", flags(), 64'd1);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        tick();
        bus_resp_valid = 1'b0;
        chk("abr_no_done", flags(), 64'd0);
        tick();
        chk("abr_idle", flags(), 64'd0);

        // Async reset mid-WAIT, then a stray response must be ignored
        set_req(1'b1, 1'b0, 64'h8000, 2'd3, 1'b0, 64'h0);
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_wait_flags", flags(), 64'd0);
        chk("rst_wait_rdata", rdata, 64'd0);
        #1 reset = 1'b0;
        clr_req();
        bus_resp_valid = 1'b1;
        tick();
        bus_resp_valid = 1'b0;
        chk("rst_wait_stray_resp", flags(), 64'd0);

        // Async reset in DONE clears held outputs without a clock edge
        set_req(1'b1, 1'b0, 64'h8008, 2'd3, 1'b0, 64'h0);
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'h0000_55AA_0000_55AA;
        tick();
        bus_resp_valid = 1'b0;
        chk("rst_done_pre", flags(), 64'h10);
        #2 reset = 1'b1;
        #1;
        chk("rst_done_flags", flags(), 64'd0);
        chk("rst_done_rdata", rdata, 64'd0);
        #1 reset = 1'b0;
        clr_req();
        tick();

        v = '{"post_reset_lb", 1'b1, 1'b0, 64'h1003, 2'd0, 1'b0, 64'h0, 64'h0000_0000_7F00_0000, 0, 0, 0, 1'b0, 1'b0, 8'h08, 64'h0, 64'h0000_0000_0000_007F};
        run_txn(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
